// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider (DIV/DIVU) for the EX stage.
// Optional feature: define DIV_EARLY_OUT_EN to finish in one cycle when |dividend| < |divisor|.
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic [2*WIDTH-1:0] result,
    output logic               ready,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [WIDTH-1:0]   raw_q, raw_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               qzero_q, qzero_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH-1:0]   abs1, abs2;
    logic               early;
    logic [WIDTH:0]     shifted, diff;
    logic [WIDTH-1:0]   rem_step, quo_step, rem_fix, quo_fix;

    // Operand magnitudes; unsigned ops pass through untouched.
    always_comb begin
        abs1 = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
        abs2 = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early = abs1 < abs2;
`else
    assign early = 1'b0;
`endif

    // One restoring step: bring in the next dividend bit, keep the difference when it does not borrow.
    always_comb begin
        shifted  = {rem_q, dvd_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};
        rem_step = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_fix  = r_neg_q ? -rem_step : rem_step;
        quo_fix  = q_neg_q ? -quo_step : quo_step;
    end

    // Next-state and datapath updates; annul beats start everywhere.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        raw_d    = raw_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        qzero_d  = qzero_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    raw_d   = opdata1;
                    dvd_d   = abs1;
                    dvs_d   = abs2;
                    rem_d   = '0;
                    quo_d   = '0;
                    cnt_d   = '0;
                    q_neg_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                    r_neg_d = signed_div & opdata1[WIDTH-1];
                    qzero_d = opdata2 != '0;
                    state_d = (opdata2 == '0 || early) ? S_ZERO : S_ON;
                end
            end
            S_ZERO: begin
                if (annul || !start) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = {raw_q, {WIDTH{~qzero_q}}};
                end
            end
            S_ON: begin
                if (annul || !start) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = rem_step;
                    quo_d = quo_step;
                    dvd_d = dvd_q << 1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d  = S_END;
                        result_d = {rem_fix, quo_fix};
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            raw_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            qzero_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            raw_q    <= raw_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            qzero_q  <= qzero_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign ready  = state_q == S_END;
    assign busy   = state_q == S_ZERO || state_q == S_ON;
endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: randomized scoreboard bench for div_seq against an arithmetic reference model.
module tb_div_seq;
    logic        clk, resetn, start, signed_div, annul;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready, busy;

    div_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .result(result), .ready(ready), .busy(busy)
    );

    typedef struct {logic [63:0] res; int cyc;} exp_t;
    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] last_res = '0;

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", n, cyc, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa, sb, qq, rr;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            qq = sa / sb;
            rr = sa % sb;
            return {rr[31:0], qq[31:0]};
        end
        return {a % b, a / b};
    endfunction

    function automatic int lat_of(input logic [31:0] a, input logic [31:0] b, input bit s);
        if (b == 0) return 2;
`ifdef DIV_EARLY_OUT_EN
        begin
            longint ma, mb;
            ma = s ? (a[31] ? -longint'($signed(a)) : longint'(a)) : longint'(a);
            mb = s ? (b[31] ? -longint'($signed(b)) : longint'(b)) : longint'(b);
            if (ma < mb) return 2;
        end
`endif
        return 33;
    endfunction

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (resetn && ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_ready @cyc %0d: got result %h, expected no ready", cyc, result);
            end else begin
                mon_e = sb.pop_front();
                chk("result", result, mon_e.res);
                chk("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit s, output int c0);
        opdata1 = a;
        opdata2 = b;
        signed_div = s;
        annul = 0;
        start = 1;
        c0 = cyc;
    endtask

    // Issue an op, hold start until ready (hazard-unit style), check busy every cycle.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input bit s, input bit scramble);
        int c0, lat;
        bit seen;
        logic [63:0] r;
        r = model(a, b, s);
        lat = lat_of(a, b, s);
        start_op(a, b, s, c0);
        sb.push_back('{r, c0 + lat});
        last_res = r;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            chk("busy", 64'(busy), 64'((cyc - c0 >= 1) && (cyc - c0 < lat)));
            if (scramble && cyc == c0 + 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
                signed_div = 1'($urandom);
            end
            if (ready) seen = 1;
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL ready_timeout: got no ready, expected ready at cyc %0d", c0 + lat);
            if (sb.size() > 0) sb.delete(0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        start = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Cancel DIVU 1000/3 in cycle 10, by annul or by dropping start.
    task automatic abort_op(input bit use_annul);
        int c0;
        start_op(32'd1000, 32'd3, 0, c0);
        for (int i = 0; i < 20 && cyc != c0 + 10; i++) @(negedge clk);
        if (use_annul) annul = 1;
        else start = 0;
        @(negedge clk);
        chk(use_annul ? "annul_busy" : "drop_busy", 64'(busy), 64'(0));
        chk(use_annul ? "annul_ready" : "drop_ready", 64'(ready), 64'(0));
        chk(use_annul ? "annul_result" : "drop_result", result, last_res);
        annul = 0;
        start = 0;
        repeat (40) @(negedge clk);
        chk("abort_result_hold", result, last_res);
        @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_on();
        int c0;
        start_op(32'd50, 32'd5, 0, c0);
        for (int i = 0; i < 30 && cyc != c0 + 15; i++) @(negedge clk);
        resetn = 0;
        #1;
        chk("rst_ready", 64'(ready), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_result", result, 64'(0));
        start = 0;
        @(negedge clk);
        resetn = 1;
        last_res = '0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] a, b;
        bit s;
        resetn = 0;
        start = 0;
        annul = 0;
        signed_div = 0;
        opdata1 = '0;
        opdata2 = '0;
        #12;
        chk("reset_ready", 64'(ready), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_result", result, 64'(0));
        @(negedge clk);
        resetn = 1;
        @(posedge clk);
        #1;
        run(32'd100, 32'd7, 0, 0);             idle(2);
        run(32'hFFFF_FFF9, 32'd2, 1, 0);       idle(1);
        run(32'd7, 32'hFFFF_FFFE, 1, 0);       idle(1);
        run(32'h1234, 32'd0, 0, 0);            idle(1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1, 0); idle(1);
        run(32'd3, 32'd10, 0, 0);              idle(1);
        run(32'd0, 32'd9, 1, 0);               idle(1);
        run(32'd50, 32'd5, 0, 0);
        run(32'd9, 32'd3, 0, 0);               idle(2);
        abort_op(1);
        abort_op(0);
        reset_mid_on();
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0: begin a = $urandom; b = 0; end
                1: begin a = $urandom_range(0, 20); b = $urandom_range(1, 20); end
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            s = 1'($urandom);
            run(a, b, s, 1'($urandom));
            if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 3));
        end
        idle(3);
        chk("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
